pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Parametrised pipeline control unit for an NSTAGE in-order pipeline, indexed
//  PC=0, IF=1 ... WB=NSTAGE. Merges per-stage stall and flush requests into
//  stall/flush vectors, with oldest-stage priority. Registers a branch/jump
//  redirect and hands it to fetch with a valid/ready handshake.
//  Flags a stall that lasts too long. Sits beside the stage registers; feeds
//  every stage's stall input, flush input and the PC redirect.
// PARAMETERS
//  NSTAGE        5   number of pipeline stages after PC (IF..WB); >=2
//  ADDR_W        32  instruction address width
//  STALL_TIMEOUT 64  consecutive stall cycles before stall_timeout_o; 0 = off
//  CNT_W         32  width of the perf counters (PIPE_CTRL_PERF_EN only)
// PORTS
//  clk              in  1               clock, rising edge
//  rst              in  1               async reset, active-low
//  stallreq_i       in  NSTAGE          bit s-1: stage s requests a stall
//  flushreq_i       in  NSTAGE          bit s-1: stage s kills younger stages and redirects
//  flush_addr_i     in  NSTAGE*ADDR_W   slice s-1: redirect target of stage s
//  stall_o          out NSTAGE+1        bit k: hold stage k (bit0 = PC)
//  flush_o          out NSTAGE+1        bit k: clear stage k to bubble; bit0 always 0
//  redirect_valid_o out 1               redirect_addr_o valid for fetch
//  redirect_addr_o  out ADDR_W          new PC
//  redirect_ready_i in  1               fetch accepts the redirect this cycle
//  stall_timeout_o  out 1               sticky: stall exceeded STALL_TIMEOUT
// BEHAVIOUR
//  - Reset (rst=0, async): FSM=IDLE, stall_o=0, flush_o=0, redirect_valid_o=0,
//    redirect_addr_o=0, timeout counter=0, stall_timeout_o=0.
//  - Stall (combinational, 0 latency): s = highest stage with stallreq set.
//    stall_o[s:0]=1, stall_o[NSTAGE:s+1]=0, flush_o[s+1]=1 (bubble into the
//    next stage; none if s=NSTAGE). No request: all 0.
//  - Flush acceptance: f = highest stage with flushreq set.
//    * Accepted only if no stallreq at stage >= f. Otherwise ignored; the
//      held stage presents it again.
//    * Accepted flush: flush_o[f-1:1]=1.
//    * stall_o[NSTAGE:1]=0: stall requests from killed younger stages do not count.
//    * stall_o[0]=1.
//    * Slice f-1 of flush_addr_i is registered into redirect_addr_o.
//    * FSM goes to REDIR.
//  - FSM IDLE: redirect_valid_o=0; stall/flush per the rules above.
//  - FSM REDIR: redirect_valid_o=1; redirect_addr_o stable while ready=0.
//    stall_o[0]=1 and flush_o[1]=1 each cycle until handshake; combine with
//    any older-stage stall by OR.
//    * ready=1 and no new accepted flush: stall_o[0]=0 (PC loads the address),
//      FSM goes to IDLE next cycle.
//    * ready=1 and a new flush accepted the same cycle: the old address is
//      consumed. The new address is registered and the FSM stays in REDIR.
//    * ready=0 and a new flush accepted: the address is overwritten, FSM stays in REDIR.
//  - Timeout: counts consecutive cycles with any stall_o[NSTAGE:1]=1 from
//    stallreq; clears on any cycle without one.
//    * Reaching STALL_TIMEOUT sets stall_timeout_o (sticky until reset).
//    * Counter saturates.
//  - Reset mid-REDIR discards the pending redirect.
// CONFIGURATION
//  PIPE_CTRL_PERF_EN defined: adds outputs stall_cycles_o and flush_count_o
//   [CNT_W]. They count cycles with stall_o[1]=1 and accepted flushes, wrap
//   on overflow and reset to 0. Not defined: the ports and logic are absent;
//   all other behaviour is identical.
// STRUCTURE
//  - Shared package/defines: FSM encodings (PC_IDLE, PC_REDIR), stage index
//    constants (STG_PC, STG_IF, STG_ID, STG_EX, STG_MEM, STG_WB).
//  - Sub-module prio_enc: priority encoder for the highest set bit, width
//    NSTAGE. Used for both stall and flush selection.
// TESTING (NSTAGE=5)
//  - stallreq_i=5'b00010 (ID) -> stall_o=6'b000111, flush_o=6'b001000.
//  - stallreq_i=5'b00110 (ID+EX) -> stall_o=6'b001111, flush_o=6'b010000.
//  - flushreq_i=5'b00100 (EX), addr=0x80 -> same cycle flush_o=6'b000110,
//    stall_o=6'b000001.
//    * Next cycle: redirect_valid_o=1, redirect_addr_o=0x80.
//    * ready low 3 cycles: address held, stall_o[0]=1.
//    * ready high -> IDLE.
//  - flushreq EX together with stallreq MEM -> flush ignored.
//    * stall_o=6'b011111, FSM stays IDLE.
//    * Release the MEM stall -> the flush is accepted that cycle.
//  - In REDIR (addr 0x80), flushreq MEM with addr 0x200 and ready=0
//    -> redirect_addr_o becomes 0x200 next cycle.
//  - STALL_TIMEOUT=4, stallreq ID held 4 cycles -> stall_timeout_o=1 after the
//    4th cycle and stays 1 after the stall releases. Async reset clears it.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit.
//   pc_state_e : redirect FSM encoding (PC_IDLE, PC_REDIR)
//   STG_*      : stage index constants for a 5-stage pipeline (PC=0 .. WB=5)
package pipe_ctrl_pkg;

    typedef enum logic {
        PC_IDLE  = 1'b0,
        PC_REDIR = 1'b1
    } pc_state_e;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

endpackage

// File: rtl/pipe_ctrl_prio_enc.sv
// Priority encoder: reports the index of the highest set request bit.
// Ports:
//   req_i   [W]      request vector
//   valid_o          at least one request bit set
//   idx_o   [IDX_W]  index of the highest set bit (0 when none)
module pipe_ctrl_prio_enc
    import pipe_ctrl_pkg::*;
#(
    parameter int W     = 5,
    parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     req_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        // Ascending scan with last-wins yields the highest set bit.
        for (int i = 0; i < W; i++) begin
            if (req_i[i]) idx_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit for an NSTAGE in-order pipeline (PC=0, IF=1 .. WB=NSTAGE).
// Merges per-stage stall/flush requests (oldest stage wins), registers the
// redirect target and hands it to fetch over a valid/ready handshake, and
// flags stalls that persist for STALL_TIMEOUT cycles.
// Optional build macro: PIPE_CTRL_PERF_EN adds stall_cycles_o / flush_count_o.
// Ports:
//   clk, rst (async, active-low)
//   stallreq_i[NSTAGE], flushreq_i[NSTAGE], flush_addr_i[NSTAGE*ADDR_W]
//   stall_o[NSTAGE+1], flush_o[NSTAGE+1]
//   redirect_valid_o, redirect_addr_o[ADDR_W], redirect_ready_i
//   stall_timeout_o (sticky)
//   stall_cycles_o, flush_count_o [CNT_W] (PIPE_CTRL_PERF_EN only)
//
// state    | meaning
// PC_IDLE  | no redirect pending
// PC_REDIR | redirect_addr_o presented to fetch, waiting for ready
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE        = 5,
    parameter int ADDR_W        = 32,
    parameter int STALL_TIMEOUT = 64,
    parameter int CNT_W         = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NSTAGE-1:0]        stallreq_i,
    input  logic [NSTAGE-1:0]        flushreq_i,
    input  logic [NSTAGE*ADDR_W-1:0] flush_addr_i,
    output logic [NSTAGE:0]          stall_o,
    output logic [NSTAGE:0]          flush_o,
    output logic                     redirect_valid_o,
    output logic [ADDR_W-1:0]        redirect_addr_o,
    input  logic                     redirect_ready_i,
`ifdef PIPE_CTRL_PERF_EN
    output logic [CNT_W-1:0]         stall_cycles_o,
    output logic [CNT_W-1:0]         flush_count_o,
`endif
    output logic                     stall_timeout_o
);

    localparam int IDX_W  = $clog2(NSTAGE);
    localparam int TO_W   = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(STALL_TIMEOUT);

    logic             st_valid, fl_valid;
    logic [IDX_W-1:0] st_idx, fl_idx;
    int               st_stage, fl_stage;
    logic             flush_acc;
    logic             stall_any;
    logic [NSTAGE:0]  stall_vec, flush_vec;

    pc_state_e         state_q;
    logic              redirect_valid_q;
    logic [ADDR_W-1:0] redirect_addr_q;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              timeout_q;
    logic              to_hit;

    pipe_ctrl_prio_enc #(.W(NSTAGE), .IDX_W(IDX_W)) u_stall_enc (
        .req_i   (stallreq_i),
        .valid_o (st_valid),
        .idx_o   (st_idx)
    );

    pipe_ctrl_prio_enc #(.W(NSTAGE), .IDX_W(IDX_W)) u_flush_enc (
        .req_i   (flushreq_i),
        .valid_o (fl_valid),
        .idx_o   (fl_idx)
    );

    // Request bit s-1 belongs to stage s.
    assign st_stage = int'(st_idx) + 1;
    assign fl_stage = int'(fl_idx) + 1;

    // A stall at or beyond the flushing stage wins; the held stage re-presents its flush later.
    assign flush_acc = fl_valid && !(st_valid && (st_stage >= fl_stage));

    always_comb begin
        stall_vec = '0;
        flush_vec = '0;
        if (flush_acc) begin
            stall_vec[STG_PC] = 1'b1;
            for (int k = 1; k <= NSTAGE; k++) begin
                if (k < fl_stage) flush_vec[k] = 1'b1;
            end
        end else if (st_valid) begin
            for (int k = 0; k <= NSTAGE; k++) begin
                if (k <= st_stage)     stall_vec[k] = 1'b1;
                if (k == st_stage + 1) flush_vec[k] = 1'b1;
            end
        end
        if (state_q == PC_REDIR) begin
            flush_vec[STG_IF] = 1'b1;
            // PC is released only on a clean handshake so it can load the new address.
            if (!(redirect_ready_i && !flush_acc)) stall_vec[STG_PC] = 1'b1;
        end
    end

    assign stall_any = |stall_vec[NSTAGE:1];

    always_comb begin
        cnt_d = '0;
        if (stall_any) cnt_d = (cnt_q == TO_MAX) ? cnt_q : cnt_q + TO_W'(1);
    end

    assign to_hit = (STALL_TIMEOUT != 0) && (cnt_d == TO_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= PC_IDLE;
            redirect_valid_q <= 1'b0;
            redirect_addr_q  <= '0;
            cnt_q            <= '0;
            timeout_q        <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (to_hit) timeout_q <= 1'b1;
            if (flush_acc) begin
                state_q          <= PC_REDIR;
                redirect_valid_q <= 1'b1;
                redirect_addr_q  <= flush_addr_i[fl_idx*ADDR_W +: ADDR_W];
            end else if (state_q == PC_REDIR && redirect_ready_i) begin
                state_q          <= PC_IDLE;
                redirect_valid_q <= 1'b0;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q, flush_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (stall_vec[STG_IF]) stall_cycles_q <= stall_cycles_q + CNT_W'(1);
            if (flush_acc)         flush_count_q  <= flush_count_q + CNT_W'(1);
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;
`endif

    assign stall_o          = stall_vec;
    assign flush_o          = flush_vec;
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_addr_o  = redirect_addr_q;
    assign stall_timeout_o  = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam int NSTAGE = 5;
    localparam int ADDR_W = 32;

    logic                     clk;
    logic                     rst;
    logic [NSTAGE-1:0]        stallreq_i;
    logic [NSTAGE-1:0]        flushreq_i;
    logic [NSTAGE*ADDR_W-1:0] flush_addr_i;
    logic [NSTAGE:0]          stall_o;
    logic [NSTAGE:0]          flush_o;
    logic                     redirect_valid_o;
    logic [ADDR_W-1:0]        redirect_addr_o;
    logic                     redirect_ready_i;
    logic                     stall_timeout_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]              stall_cycles_o;
    logic [31:0]              flush_count_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pipe_ctrl #(
        .NSTAGE(NSTAGE), .ADDR_W(ADDR_W), .STALL_TIMEOUT(4), .CNT_W(32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stallreq_i       (stallreq_i),
        .flushreq_i       (flushreq_i),
        .flush_addr_i     (flush_addr_i),
        .stall_o          (stall_o),
        .flush_o          (flush_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_addr_o  (redirect_addr_o),
        .redirect_ready_i (redirect_ready_i),
`ifdef PIPE_CTRL_PERF_EN
        .stall_cycles_o   (stall_cycles_o),
        .flush_count_o    (flush_count_o),
`endif
        .stall_timeout_o  (stall_timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int stage, input logic [ADDR_W-1:0] a);
        flush_addr_i[(stage-1)*ADDR_W +: ADDR_W] = a;
    endtask

    initial begin
        rst              = 1'b0;
        stallreq_i       = '0;
        flushreq_i       = '0;
        flush_addr_i     = '0;
        redirect_ready_i = 1'b0;
        #1;
        chk("rst_stall", stall_o, 6'b000000);
        chk("rst_flush", flush_o, 6'b000000);
        chk("rst_valid", redirect_valid_o, 1'b0);
        chk("rst_addr", redirect_addr_o, 32'h0);
        chk("rst_timeout", stall_timeout_o, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // combinational stall merging, no clock edge in between
        stallreq_i = 5'b00010; #1;
        chk("stall_id_st", stall_o, 6'b000111);
        chk("stall_id_fl", flush_o, 6'b001000);
        stallreq_i = 5'b00110; #1;
        chk("stall_idex_st", stall_o, 6'b001111);
        chk("stall_idex_fl", flush_o, 6'b010000);
        stallreq_i = 5'b10000; #1;
        chk("stall_wb_st", stall_o, 6'b111111);
        chk("stall_wb_fl", flush_o, 6'b000000);
        stallreq_i = '0; #1;
        chk("idle_st", stall_o, 6'b000000);

        // flush from EX
        set_addr(3, 32'h80);
        flushreq_i = 5'b00100; #1;
        chk("fl_ex_fl", flush_o, 6'b000110);
        chk("fl_ex_st", stall_o, 6'b000001);
        chk("fl_ex_valid0", redirect_valid_o, 1'b0);
        tick();
        flushreq_i = '0; #1;
        for (int i = 0; i < 3; i++) begin
            chk("redir_valid", redirect_valid_o, 1'b1);
            chk("redir_addr", redirect_addr_o, 32'h80);
            chk("redir_st", stall_o, 6'b000001);
            chk("redir_fl", flush_o, 6'b000010);
            tick();
        end
        redirect_ready_i = 1'b1; #1;
        chk("handshake_st0", stall_o[0], 1'b0);
        tick();
        redirect_ready_i = 1'b0; #1;
        chk("after_hs_valid", redirect_valid_o, 1'b0);
        chk("after_hs_st", stall_o, 6'b000000);

        // flush EX blocked by older MEM stall
        stallreq_i = 5'b01000;
        flushreq_i = 5'b00100; #1;
        chk("blk_st", stall_o, 6'b011111);
        chk("blk_fl", flush_o, 6'b100000);
        tick();
        chk("blk_valid", redirect_valid_o, 1'b0);
        stallreq_i = '0; #1;
        chk("rel_fl", flush_o, 6'b000110);
        chk("rel_st", stall_o, 6'b000001);
        tick();
        flushreq_i = '0; #1;
        chk("rel_valid", redirect_valid_o, 1'b1);
        chk("rel_addr", redirect_addr_o, 32'h80);

        // overwrite in REDIR with ready low: MEM flush to 0x200
        set_addr(4, 32'h200);
        flushreq_i = 5'b01000; #1;
        chk("ovw_fl", flush_o, 6'b001110);
        chk("ovw_st", stall_o, 6'b000001);
        tick();
        flushreq_i = '0; #1;
        chk("ovw_addr", redirect_addr_o, 32'h200);
        chk("ovw_valid", redirect_valid_o, 1'b1);

        // ready together with a new ID flush: stays in REDIR with new address
        set_addr(2, 32'h300);
        flushreq_i       = 5'b00010;
        redirect_ready_i = 1'b1; #1;
        chk("rf_st", stall_o, 6'b000001);
        chk("rf_fl", flush_o, 6'b000010);
        tick();
        flushreq_i       = '0;
        redirect_ready_i = 1'b0; #1;
        chk("rf_valid", redirect_valid_o, 1'b1);
        chk("rf_addr", redirect_addr_o, 32'h300);
        redirect_ready_i = 1'b1; #1;
        chk("rf_hs_st0", stall_o[0], 1'b0);
        tick();
        redirect_ready_i = 1'b0; #1;
        chk("rf_idle", redirect_valid_o, 1'b0);

        // counter clears on a stall-free cycle: 3 + gap + 3 never times out
        stallreq_i = 5'b00010;
        tick(); tick(); tick();
        stallreq_i = '0;
        tick();
        stallreq_i = 5'b00010;
        tick(); tick(); tick();
        stallreq_i = '0;
        tick();
        chk("to_gap", stall_timeout_o, 1'b0);

        // 4 consecutive stall cycles
        stallreq_i = 5'b00010;
        tick(); tick(); tick();
        chk("to_3", stall_timeout_o, 1'b0);
        tick();
        chk("to_4", stall_timeout_o, 1'b1);
        stallreq_i = '0;
        tick(); tick();
        chk("to_sticky", stall_timeout_o, 1'b1);
        rst = 1'b0; #1;
        chk("to_rst", stall_timeout_o, 1'b0);
        rst = 1'b1;
        tick();

        // reset mid-REDIR discards the redirect
        set_addr(3, 32'h440);
        flushreq_i = 5'b00100;
        tick();
        flushreq_i = '0; #1;
        chk("mr_valid", redirect_valid_o, 1'b1);
        chk("mr_addr", redirect_addr_o, 32'h440);
        rst = 1'b0; #1;
        chk("mr_rst_valid", redirect_valid_o, 1'b0);
        chk("mr_rst_addr", redirect_addr_o, 32'h0);
        chk("mr_rst_st", stall_o, 6'b000000);
        rst = 1'b1;
        tick();
        chk("mr_after", redirect_valid_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
